// File: rtl/mmio_bus_responder.sv
// mmio_bus_responder: IO-window responder on the CPU data-memory bus.
// Holds LED / display / SEG_DRV registers, samples switches and buttons
// through two-flop synchronisers, and provides a free-running compare timer
// with a sticky match flag. Read data is registered (one-cycle latency).
// Build option: define MMIO_BTN_EDGE_EN to add the BEDGE button rising-edge
// capture register at offset 0x20; without it that offset reads 0.
module mmio_bus_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'hFFFF_FF00,
    parameter logic [31:0] TIMER_CMP_RST = 32'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    input  logic [15:0] sw,
    input  logic [3:0]  btn,
    output logic [7:0]  ledOut,
    output logic [15:0] dispOut,
    output logic [31:0] segNums,
    output logic        timerFlag
);

    // Word index (address[7:2]) of each register in the window.
    localparam logic [5:0] W_SW    = 6'h00;
    localparam logic [5:0] W_BTN   = 6'h01;
    localparam logic [5:0] W_LED   = 6'h02;
    localparam logic [5:0] W_DISP  = 6'h03;
    localparam logic [5:0] W_SEG   = 6'h04;
    localparam logic [5:0] W_TCNT  = 6'h05;
    localparam logic [5:0] W_TCMP  = 6'h06;
    localparam logic [5:0] W_STAT  = 6'h07;
    localparam logic [5:0] W_BEDGE = 6'h08;

    logic [5:0]  word;
    logic        wr_en;
    logic        rd_en;
    logic        timer_match;
    logic [31:0] rd_val;

    logic [15:0] sw_meta_q, sw_sync_q;
    logic [3:0]  btn_meta_q, btn_sync_q;

    logic [31:0] rdata_q;
    logic [7:0]  led_q, led_d;
    logic [15:0] disp_q, disp_d;
    logic [31:0] seg_q, seg_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        flag_q, flag_d;
    logic        ten_q, ten_d;

    // Byte lane bits are meaningless on this word-only bus.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^address[1:0];

    assign word        = address[7:2];
    assign hit         = (address[31:8] == BASE_ADDR[31:8]);
    assign wr_en       = writeEnable & hit;
    assign rd_en       = readEnable & hit;
    assign timer_match = ten_q && (tcnt_q == tcmp_q);

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef MMIO_BTN_EDGE_EN
    logic [3:0] bedge_q, bedge_d;

    // Edge capture: a bit rises together with btn_sync; a set beats a
    // same-cycle W1C of that bit.
    always_comb begin
        bedge_d = bedge_q;
        if (wr_en && (word == W_BEDGE)) begin
            bedge_d = bedge_q & ~writeData[3:0];
        end
        bedge_d = bedge_d | (btn_meta_q & ~btn_sync_q);
    end

    // Edge capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bedge_q <= '0;
        end else begin
            bedge_q <= bedge_d;
        end
    end
`endif

    // Read decode from current (pre-write) register contents.
    always_comb begin
        rd_val = '0;
        case (word)
            W_SW:    rd_val = {16'b0, sw_sync_q};
            W_BTN:   rd_val = {28'b0, btn_sync_q};
            W_LED:   rd_val = {24'b0, led_q};
            W_DISP:  rd_val = {16'b0, disp_q};
            W_SEG:   rd_val = seg_q;
            W_TCNT:  rd_val = tcnt_q;
            W_TCMP:  rd_val = tcmp_q;
            W_STAT:  rd_val = {30'b0, ten_q, flag_q};
`ifdef MMIO_BTN_EDGE_EN
            W_BEDGE: rd_val = {28'b0, bedge_q};
`endif
            default: rd_val = '0;
        endcase
    end

    // Register next-state: timer advance, then CPU writes override it,
    // then a compare match forces the flag set over any W1C.
    always_comb begin
        led_d  = led_q;
        disp_d = disp_q;
        seg_d  = seg_q;
        tcnt_d = tcnt_q;
        tcmp_d = tcmp_q;
        flag_d = flag_q;
        ten_d  = ten_q;

        if (ten_q) begin
            tcnt_d = timer_match ? 32'd0 : tcnt_q + 32'd1;
        end

        if (wr_en) begin
            case (word)
                W_LED:  led_d  = writeData[7:0];
                W_DISP: disp_d = writeData[15:0];
                W_SEG:  seg_d  = writeData;
                W_TCNT: tcnt_d = writeData;
                W_TCMP: tcmp_d = writeData;
                W_STAT: begin
                    if (writeData[0]) begin
                        flag_d = 1'b0;
                    end
                    ten_d = writeData[1];
                end
                default: ;
            endcase
        end

        if (timer_match) begin
            flag_d = 1'b1;
        end
    end

    // Register file and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            led_q   <= '0;
            disp_q  <= '0;
            seg_q   <= '0;
            tcnt_q  <= '0;
            tcmp_q  <= TIMER_CMP_RST;
            flag_q  <= 1'b0;
            ten_q   <= 1'b0;
        end else begin
            if (rd_en) begin
                rdata_q <= rd_val;
            end
            led_q  <= led_d;
            disp_q <= disp_d;
            seg_q  <= seg_d;
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
            flag_q <= flag_d;
            ten_q  <= ten_d;
        end
    end

    assign readData  = rdata_q;
    assign ledOut    = led_q;
    assign dispOut   = disp_q;
    assign segNums   = seg_q;
    assign timerFlag = flag_q;

endmodule

// File: tb/tb_mmio_bus_responder.sv
// Self-checking bench for mmio_bus_responder: directed steps followed by a
// randomized bus/input sequence, all checked against a register-level model.
// Honours MMIO_BTN_EDGE_EN the same way the design does.
module tb_mmio_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic        readEnable;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        hit;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [7:0]  ledOut;
    logic [15:0] dispOut;
    logic [31:0] segNums;
    logic        timerFlag;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (what a software view of the register map holds).
    logic [31:0] m_rdata, m_seg, m_tcnt, m_tcmp;
    logic [15:0] m_disp;
    logic [7:0]  m_led;
    logic        m_flag, m_en;
    logic [15:0] m_sw_hist [2];
    logic [3:0]  m_btn_hist [2];
`ifdef MMIO_BTN_EDGE_EN
    logic [3:0]  m_bedge;
`endif

    mmio_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .readEnable  (readEnable),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .readData    (readData),
        .hit         (hit),
        .sw          (sw),
        .btn         (btn),
        .ledOut      (ledOut),
        .dispOut     (dispOut),
        .segNums     (segNums),
        .timerFlag   (timerFlag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_rdata = 0; m_led = 0; m_disp = 0; m_seg = 0;
        m_tcnt = 0; m_tcmp = 32'd1000; m_flag = 0; m_en = 0;
        m_sw_hist[0] = 0; m_sw_hist[1] = 0;
        m_btn_hist[0] = 0; m_btn_hist[1] = 0;
`ifdef MMIO_BTN_EDGE_EN
        m_bedge = 0;
`endif
    endtask

    // Synced inputs are what was on the pins two edges ago.
    function automatic logic [31:0] m_read(input logic [7:0] off);
        case (off)
            8'h00: return {16'b0, m_sw_hist[1]};
            8'h04: return {28'b0, m_btn_hist[1]};
            8'h08: return {24'b0, m_led};
            8'h0C: return {16'b0, m_disp};
            8'h10: return m_seg;
            8'h14: return m_tcnt;
            8'h18: return m_tcmp;
            8'h1C: return {30'b0, m_en, m_flag};
`ifdef MMIO_BTN_EDGE_EN
            8'h20: return {28'b0, m_bedge};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_edge(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        bit          in_win;
        bit          match;
        logic [7:0]  off;
        logic [3:0]  new_btn_sync;
        in_win = (a[31:8] == 24'hFFFFFF);
        off    = {a[7:2], 2'b00};
        if (rd && in_win) m_rdata = m_read(off);
        match = m_en && (m_tcnt == m_tcmp);
        if (m_en) m_tcnt = match ? 32'd0 : m_tcnt + 32'd1;
        if (wr && in_win) begin
            case (off)
                8'h08: m_led  = wd[7:0];
                8'h0C: m_disp = wd[15:0];
                8'h10: m_seg  = wd;
                8'h14: m_tcnt = wd;
                8'h18: m_tcmp = wd;
                8'h1C: begin
                    if (wd[0]) m_flag = 1'b0;
                    m_en = wd[1];
                end
`ifdef MMIO_BTN_EDGE_EN
                8'h20: m_bedge = m_bedge & ~wd[3:0];
`endif
                default: ;
            endcase
        end
        if (match) m_flag = 1'b1;
        new_btn_sync = m_btn_hist[0];
`ifdef MMIO_BTN_EDGE_EN
        m_bedge = m_bedge | (new_btn_sync & ~m_btn_hist[1]);
`endif
        m_sw_hist[1]  = m_sw_hist[0];  m_sw_hist[0]  = sw;
        m_btn_hist[1] = new_btn_sync;  m_btn_hist[0] = btn;
    endtask

    task automatic check_outs();
        chk("readData",  readData, m_rdata);
        chk("ledOut",    {24'b0, ledOut}, {24'b0, m_led});
        chk("dispOut",   {16'b0, dispOut}, {16'b0, m_disp});
        chk("segNums",   segNums, m_seg);
        chk("timerFlag", {31'b0, timerFlag}, {31'b0, m_flag});
    endtask

    // One bus cycle: drive at negedge, check hit, clock, check outputs.
    task automatic cyc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        readEnable = rd; writeEnable = wr; address = a; writeData = wd;
        #1;
        chk("hit", {31'b0, hit}, {31'b0, (a[31:8] == 24'hFFFFFF)});
        @(posedge clk);
        m_edge(rd, wr, a, wd);
        #1;
        check_outs();
    endtask

    task automatic rd_reg(input logic [7:0] off);
        cyc(1'b1, 1'b0, {24'hFFFFFF, off}, 32'd0);
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] wd);
        cyc(1'b0, 1'b1, {24'hFFFFFF, off}, wd);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [7:0]  off_r;
        bit          rd, wr;

        rst = 1'b1; address = 0; readEnable = 0; writeEnable = 0;
        writeData = 0; sw = 0; btn = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs();

        // Reset values.
        rd_reg(8'h08); chk("rst_led_rd",  readData, 32'd0);
        rd_reg(8'h0C); chk("rst_disp_rd", readData, 32'd0);
        rd_reg(8'h10); chk("rst_seg_rd",  readData, 32'd0);
        rd_reg(8'h1C); chk("rst_stat_rd", readData, 32'd0);
        rd_reg(8'h18); chk("rst_tcmp_rd", readData, 32'd1000);

        // Narrow register write and readback.
        wr_reg(8'h08, 32'h1234_56A5); chk("led_wr", {24'b0, ledOut}, 32'h0000_00A5);
        rd_reg(8'h08); chk("led_rd", readData, 32'h0000_00A5);
        wr_reg(8'h10, 32'hDEAD_BEEF); chk("seg_wr", segNums, 32'hDEAD_BEEF);

        // Outside the window / unmapped offset.
        cyc(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0055);
        chk("miss_led", {24'b0, ledOut}, 32'h0000_00A5);
        rd_reg(8'h40); chk("unmapped_rd", readData, 32'd0);

        // Same-cycle read and write returns the pre-write value.
        cyc(1'b1, 1'b1, 32'hFFFF_FF08, 32'h0000_003C);
        chk("rw_same", readData, 32'h0000_00A5);
        chk("rw_led", {24'b0, ledOut}, 32'h0000_003C);

        // Switch input latency.
        sw = 16'h00C3;
        idle();
        rd_reg(8'h00); chk("sw_early", readData, 32'd0);
        rd_reg(8'h00); chk("sw_sync",  readData, 32'h0000_00C3);

        // Timer count sequence and match.
        wr_reg(8'h18, 32'd3);
        wr_reg(8'h14, 32'd0);
        wr_reg(8'h1C, 32'd2);
        rd_reg(8'h14); chk("tcnt0", readData, 32'd0);
        rd_reg(8'h14); chk("tcnt1", readData, 32'd1);
        rd_reg(8'h14); chk("tcnt2", readData, 32'd2);
        chk("flag_pre", {31'b0, timerFlag}, 32'd0);
        rd_reg(8'h14); chk("tcnt3", readData, 32'd3);
        chk("flag_set", {31'b0, timerFlag}, 32'd1);
        rd_reg(8'h14); chk("tcnt_wrap0", readData, 32'd0);
        wr_reg(8'h1C, 32'd3); chk("flag_w1c", {31'b0, timerFlag}, 32'd0);
        rd_reg(8'h1C); chk("stat_en", readData, 32'd2);
        wr_reg(8'h1C, 32'd3); chk("flag_set_wins", {31'b0, timerFlag}, 32'd1);
        idle();
        idle();
        rd_reg(8'h14); chk("tcnt_before_rst", readData, 32'd2);

        // Async reset mid-timer, with a write pending during reset.
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_outs();
        chk("rst_flag_now", {31'b0, timerFlag}, 32'd0);
        @(negedge clk);
        writeEnable = 1'b1; address = 32'hFFFF_FF08; writeData = 32'hFF;
        @(posedge clk); #1;
        check_outs();
        @(negedge clk);
        rst = 1'b0; writeEnable = 1'b0;
        rd_reg(8'h14); chk("rst_tcnt", readData, 32'd0);
        rd_reg(8'h1C); chk("rst_stat", readData, 32'd0);
        rd_reg(8'h18); chk("rst_tcmp", readData, 32'd1000);

        // Counter wraps past all-ones.
        wr_reg(8'h18, 32'd5);
        wr_reg(8'h14, 32'hFFFF_FFFF);
        wr_reg(8'h1C, 32'd2);
        rd_reg(8'h14); chk("tcnt_max", readData, 32'hFFFF_FFFF);
        rd_reg(8'h14); chk("tcnt_wrap", readData, 32'd0);

        // Compare of zero: match every cycle, flag cannot be cleared.
        wr_reg(8'h18, 32'd0);
        wr_reg(8'h14, 32'd0);
        wr_reg(8'h1C, 32'd3);
        wr_reg(8'h1C, 32'd3); chk("cmp0_flag", {31'b0, timerFlag}, 32'd1);
        wr_reg(8'h1C, 32'd1);

        // Button edge register (or its absence).
        btn = 4'b0010;
        idle(); idle(); idle();
`ifdef MMIO_BTN_EDGE_EN
        rd_reg(8'h20); chk("bedge_set", readData, 32'd2);
        wr_reg(8'h20, 32'd2);
        rd_reg(8'h20); chk("bedge_clr", readData, 32'd0);
`else
        wr_reg(8'h20, 32'hF);
        rd_reg(8'h20); chk("bedge_absent", readData, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) sw  = 16'($urandom);
            if ($urandom_range(0, 5) == 0) btn = 4'($urandom);
            case ($urandom_range(0, 9))
                8:       a = {24'hFFFFFF, 8'($urandom_range(36, 255))};
                9:       a = $urandom & 32'h7FFF_FFFF;
                default: begin
                    off_r = 8'($urandom_range(0, 8) * 4 + $urandom_range(0, 3));
                    a = {24'hFFFFFF, off_r};
                end
            endcase
            if (a[7:2] == 6'h05 || a[7:2] == 6'h06) wd = $urandom_range(0, 12);
            else                                   wd = $urandom;
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            cyc(rd, wr, a, wd);
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
